pipe_stage_skid: RTL

//  Parametrised pipeline stage register: successor to the fixed-field inter-stage latches.

---
 rtl/pipe_stage_skid.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush (bubble insertion), control masking on bubbles and sticky HALT capture.
module pipe_stage_skid #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned CTRL_W  = 8,
   parameter int unsigned SKID_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_halt,
   output logic              halt_seen,
   output logic [1:0]        occupancy
);

   logic              mFullQ, mFullD;
   logic [DATA_W-1:0] mDataQ, mDataD;
   logic [CTRL_W-1:0] mCtrlQ, mCtrlD;
   logic              mHaltQ, mHaltD;
   logic              sFullQ, sFullD;
   logic [DATA_W-1:0] sDataQ, sDataD;
   logic [CTRL_W-1:0] sCtrlQ, sCtrlD;
   logic              sHaltQ, sHaltD;
   logic              haltSeenQ, haltSeenD;
   logic              inReadyQ, inReadyD;
   logic              acceptW, emitW;

   assign acceptW = in_valid & in_ready;
   assign emitW   = mFullQ & out_ready;

   always_comb begin
      mFullD    = mFullQ;
      mDataD    = mDataQ;
      mCtrlD    = mCtrlQ;
      mHaltD    = mHaltQ;
      sFullD    = sFullQ;
      sDataD    = sDataQ;
      sCtrlD    = sCtrlQ;
      sHaltD    = sHaltQ;
      haltSeenD = haltSeenQ;
      if (flush) begin
         // Flush dominates: any same-cycle accept or emit is discarded.
         mFullD    = 1'b0;
         mDataD    = '0;
         mCtrlD    = '0;
         mHaltD    = 1'b0;
         sFullD    = 1'b0;
         sDataD    = '0;
         sCtrlD    = '0;
         sHaltD    = 1'b0;
         haltSeenD = 1'b0;
      end else begin
         haltSeenD = haltSeenQ | (acceptW & in_halt);
         if (emitW && sFullQ) begin
            mDataD = sDataQ;
            mCtrlD = sCtrlQ;
            mHaltD = sHaltQ;
            sFullD = 1'b0;
         end else if (emitW) begin
            mFullD = acceptW;
            if (acceptW) begin
               mDataD = in_data;
               mCtrlD = in_ctrl;
               mHaltD = in_halt;
            end
         end else if (acceptW) begin
            if (!mFullQ) begin
               mFullD = 1'b1;
               mDataD = in_data;
               mCtrlD = in_ctrl;
               mHaltD = in_halt;
            end else if (SKID_EN != 0) begin
               sFullD = 1'b1;
               sDataD = in_data;
               sCtrlD = in_ctrl;
               sHaltD = in_halt;
            end
         end
      end
      inReadyD = ~sFullD & ~haltSeenD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mFullQ    <= 1'b0;
         mDataQ    <= '0;
         mCtrlQ    <= '0;
         mHaltQ    <= 1'b0;
         sFullQ    <= 1'b0;
         sDataQ    <= '0;
         sCtrlQ    <= '0;
         sHaltQ    <= 1'b0;
         haltSeenQ <= 1'b0;
         inReadyQ  <= 1'b1;
      end else begin
         mFullQ    <= mFullD;
         mDataQ    <= mDataD;
         mCtrlQ    <= mCtrlD;
         mHaltQ    <= mHaltD;
         sFullQ    <= sFullD;
         sDataQ    <= sDataD;
         sCtrlQ    <= sCtrlD;
         sHaltQ    <= sHaltD;
         haltSeenQ <= haltSeenD;
         inReadyQ  <= inReadyD;
      end
   end

   // Skid mode keeps in_ready registered so out_ready never reaches it combinationally.
   assign in_ready  = (SKID_EN != 0) ? inReadyQ : ((~mFullQ | out_ready) & ~haltSeenQ);
   assign out_valid = mFullQ;
   assign out_data  = mDataQ;
   assign out_ctrl  = mCtrlQ & {CTRL_W{mFullQ}};
   assign out_halt  = mHaltQ & mFullQ;
   assign halt_seen = haltSeenQ;
   assign occupancy = {1'b0, mFullQ} + {1'b0, sFullQ};

endmodule
